// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
//   REG_AW / DATA_W / NREG : register-file geometry (register 0 reads as zero)
//   MAX_OUT                : MD operations that may be issued but not yet written back
//   STARVE_LIM             : cycles a buffered MD result may lose arbitration before issue freezes
//   wr_req_t               : one register-file write (destination + data)
package regfile_sched_pkg;

  localparam int REG_AW     = 5;
  localparam int DATA_W     = 32;
  localparam int NREG       = 32;
  localparam int MAX_OUT    = 4;
  localparam int STARVE_LIM = 3;

  localparam int OUT_W    = $clog2(MAX_OUT + 1);
  localparam int STARVE_W = $clog2(STARVE_LIM + 1);

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of every non-clock signal around the write scheduler.
//   issue_* : decode issue request and its stall
//   wb_*    : pipeline writeback (never back-pressured)
//   md_*    : multiply/divide result handshake
//   rf_*    : registered register-file write port
//   busy_mask : scoreboard view, bit r = MD write to r pending
// slave is the scheduler's view, master is the surrounding pipeline's view.
interface regfile_write_scheduler_if;
  import regfile_sched_pkg::*;

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_md;
  logic              issue_stall;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              md_valid;
  logic [REG_AW-1:0] md_reg;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [NREG-1:0]   busy_mask;

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_md,
    output issue_stall,
    input  wb_valid, wb_reg, wb_data,
    input  md_valid, md_reg, md_data,
    output md_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy_mask
  );

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_md,
    input  issue_stall,
    output wb_valid, wb_reg, wb_data,
    output md_valid, md_reg, md_data,
    input  md_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy_mask
  );

endinterface

// File: rtl/md_result_fifo.sv
// Two-entry FIFO buffering MD results until they win the register-file port.
//   clock, reset : system clock, async active-low reset (empties the FIFO)
//   push, push_data : enqueue; caller only pushes when !full
//   pop, head       : dequeue / current oldest entry; caller only pops when !empty
//   full, empty     : occupancy flags
module md_result_fifo
  import regfile_sched_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  wr_req_t    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  // NOTE: storage is deliberately left out of reset; count decides which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owner of the single register-file write port.
//   clock : system clock
//   reset : async active-low reset
//   bus   : issue / writeback / MD / register-file signals (slave view)
// Pipeline writeback always wins the port; buffered MD results take any free
// slot. A busy scoreboard stalls issue on RAW/WAW hazards against pending MD
// results, and a starvation counter freezes issue so writeback bubbles appear.
module regfile_write_scheduler
  import regfile_sched_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  regfile_write_scheduler_if.slave bus
);

  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     busy_next;
  logic [OUT_W-1:0]    outstanding;
  logic [STARVE_W-1:0] starve_cnt;

  wr_req_t md_req;
  wr_req_t head;
  logic    full;
  logic    empty;

  logic push;
  logic pop;
  logic wb_win;
  logic freeze;
  logic stall;
  logic accept;
  logic set_busy;
  logic clr_busy;

  assign md_req = '{addr: bus.md_reg, data: bus.md_data};

  md_result_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (md_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Writes to register 0 are dropped, so they do not claim the port.
  assign wb_win = bus.wb_valid & (bus.wb_reg != '0);
  assign pop    = ~wb_win & ~empty;
  assign push   = bus.md_valid & ~full;

  assign freeze = (starve_cnt >= STARVE_W'(STARVE_LIM));

  assign stall = bus.issue_valid &
                 (busy[bus.issue_rs] | busy[bus.issue_rt] | busy[bus.issue_rd] |
                  (bus.issue_md & (outstanding == OUT_W'(MAX_OUT))) |
                  freeze);

  assign accept   = bus.issue_valid & ~stall;
  assign set_busy = accept & bus.issue_md & (bus.issue_rd != '0);
  // Results with no pending busy bit are still written but leave the
  // scoreboard and outstanding count untouched.
  assign clr_busy = pop & busy[head.addr];

  // The WAW stall keeps set and clear on different registers in one cycle.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and starts from a
    // full default so no latch is inferred.
    busy_next = busy;
    if (clr_busy) busy_next[head.addr] = 1'b0;
    if (set_busy) busy_next[bus.issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      outstanding <= '0;
      starve_cnt  <= '0;
    end else begin
      busy <= busy_next;

      case ({set_busy, clr_busy})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (pop) begin
        starve_cnt <= '0;
      end else if (!empty && wb_win && !freeze) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  // Write port register: address/data hold their last written value when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (wb_win) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= bus.wb_reg;
      bus.rf_wdata <= bus.wb_data;
    end else if (pop && head.addr != '0) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= head.addr;
      bus.rf_wdata <= head.data;
    end else begin
      bus.rf_we    <= 1'b0;
    end
  end

  assign bus.issue_stall = stall;
  assign bus.md_ready    = ~full;
  assign bus.busy_mask   = busy;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model of the scheduling rules.
module tb_regfile_write_scheduler;
  import regfile_sched_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_scheduler_if bus();

  regfile_write_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  wr_req_t     q[$];
  bit [31:0]   m_busy;
  int          m_out;
  int          m_starve;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  // Expected / observed per cycle
  logic        exp_stall, exp_ready, exp_we;
  logic        obs_stall, obs_ready, obs_we;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata, obs_busy;

  function automatic void model_reset();
    q.delete();
    m_busy   = '0;
    m_out    = 0;
    m_starve = 0;
    m_waddr  = '0;
    m_wdata  = '0;
  endfunction

  // One clock cycle: drive inputs, sample combinational outputs before the
  // edge, advance the model, sample registered outputs after the edge.
  task automatic cycle(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic imd,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdd);
    wr_req_t h;
    wr_req_t n;
    int      sz0;
    bit      wb_win, popped, accept;
    bus.issue_valid = iv; bus.issue_rs = rs; bus.issue_rt = rt;
    bus.issue_rd = rd;    bus.issue_md = imd;
    bus.wb_valid = wv;    bus.wb_reg = wr;   bus.wb_data = wd;
    bus.md_valid = mv;    bus.md_reg = mr;   bus.md_data = mdd;
    #1;
    obs_stall = bus.issue_stall;
    obs_ready = bus.md_ready;

    sz0       = q.size();
    exp_ready = (sz0 < 2);
    exp_stall = iv && (m_busy[rs] || m_busy[rt] || m_busy[rd] ||
                       (imd && m_out == MAX_OUT) || (m_starve >= STARVE_LIM));
    accept    = iv && !exp_stall;
    wb_win    = wv && (wr != 5'd0);
    popped    = 1'b0;
    exp_we    = 1'b0;
    if (wb_win) begin
      exp_we = 1'b1; m_waddr = wr; m_wdata = wd;
    end else if (sz0 > 0) begin
      h = q.pop_front();
      popped = 1'b1;
      if (h.addr != 5'd0) begin
        exp_we = 1'b1; m_waddr = h.addr; m_wdata = h.data;
      end
      if (m_busy[h.addr]) begin
        m_busy[h.addr] = 1'b0;
        m_out--;
      end
    end
    if (mv && exp_ready) begin
      n.addr = mr; n.data = mdd;
      q.push_back(n);
    end
    if (popped) m_starve = 0;
    else if (sz0 > 0 && wb_win && m_starve < STARVE_LIM) m_starve++;
    if (accept && imd && rd != 5'd0) begin
      m_busy[rd] = 1'b1;
      m_out++;
    end

    @(posedge clock);
    #1;
    obs_we    = bus.rf_we;
    obs_waddr = bus.rf_waddr;
    obs_wdata = bus.rf_wdata;
    obs_busy  = bus.busy_mask;
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (4) begin
      bus.issue_valid = 1'($urandom); bus.issue_rs = 5'($urandom); bus.issue_rt = 5'($urandom);
      bus.issue_rd = 5'($urandom);    bus.issue_md = 1'($urandom);
      bus.wb_valid = 1'($urandom);    bus.wb_reg = 5'($urandom);   bus.wb_data = $urandom;
      bus.md_valid = 1'($urandom);    bus.md_reg = 5'($urandom);   bus.md_data = $urandom;
      @(posedge clock);
      #1;
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%0b exp=0", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%0d exp=0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%h exp=0", bus.rf_wdata); end
      checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", bus.busy_mask); end
      checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready got=%0b exp=1", bus.md_ready); end
      checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.issue_stall); end
    end
    @(negedge clock);
    reset = 1'b1;
    idle();
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL post_reset_we got=%0b exp=0", obs_we); end
    checks++; if (obs_busy !== 32'd0) begin errors++; $display("FAIL post_reset_busy got=%h exp=0", obs_busy); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%0b exp=1", obs_ready); end
  endtask

  task automatic test_wb_only();
    cycle(0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0);
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL wb_we got=%0b exp=1", obs_we); end
    checks++; if (obs_waddr !== 5'd5) begin errors++; $display("FAIL wb_waddr got=%0d exp=5", obs_waddr); end
    checks++; if (obs_wdata !== 32'h1234) begin errors++; $display("FAIL wb_wdata got=%h exp=1234", obs_wdata); end
    cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'h5555, 0, 0, 0);
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL wb_reg0_we got=%0b exp=0", obs_we); end
  endtask

  task automatic test_raw();
    cycle(1, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL raw_issue_md_stall got=%0b exp=0", obs_stall); end
    checks++; if (obs_busy[8] !== 1'b1) begin errors++; $display("FAIL raw_busy_set got=%0b exp=1", obs_busy[8]); end
    cycle(1, 5'd8, 0, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%0b exp=1", obs_stall); end
    cycle(1, 5'd8, 0, 5'd9, 0, 0, 0, 0, 1, 5'd8, 32'hAA);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_push got=%0b exp=1", obs_stall); end
    cycle(1, 5'd8, 0, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_pop got=%0b exp=1", obs_stall); end
    checks++; if (obs_we !== 1'b1 || obs_waddr !== 5'd8 || obs_wdata !== 32'hAA) begin
      errors++; $display("FAIL raw_write got=%0b/%0d/%h exp=1/8/aa", obs_we, obs_waddr, obs_wdata); end
    checks++; if (obs_busy[8] !== 1'b0) begin errors++; $display("FAIL raw_busy_clear got=%0b exp=0", obs_busy[8]); end
    cycle(1, 5'd8, 0, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_drop got=%0b exp=0", obs_stall); end
  endtask

  task automatic test_conflict();
    cycle(0, 0, 0, 0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    checks++; if (obs_waddr !== 5'd3 || obs_wdata !== 32'h33) begin
      errors++; $display("FAIL conflict_wb_first got=%0d/%h exp=3/33", obs_waddr, obs_wdata); end
    idle();
    checks++; if (obs_we !== 1'b1 || obs_waddr !== 5'd4 || obs_wdata !== 32'h44) begin
      errors++; $display("FAIL conflict_md_next got=%0b/%0d/%h exp=1/4/44", obs_we, obs_waddr, obs_wdata); end
    cycle(0, 0, 0, 0, 0, 1, 5'd6, 32'h60, 1, 5'd7, 32'h70);
    cycle(0, 0, 0, 0, 0, 1, 5'd6, 32'h61, 1, 5'd9, 32'h90);
    cycle(0, 0, 0, 0, 0, 1, 5'd6, 32'h62, 1, 5'd10, 32'hA0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL conflict_full_ready got=%0b exp=0", obs_ready); end
    idle();
    checks++; if (obs_waddr !== 5'd7 || obs_wdata !== 32'h70) begin
      errors++; $display("FAIL conflict_drain0 got=%0d/%h exp=7/70", obs_waddr, obs_wdata); end
    idle();
    checks++; if (obs_waddr !== 5'd9 || obs_wdata !== 32'h90) begin
      errors++; $display("FAIL conflict_drain1 got=%0d/%h exp=9/90", obs_waddr, obs_wdata); end
    idle();
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL conflict_empty_we got=%0b exp=0", obs_we); end
  endtask

  task automatic test_starvation();
    cycle(0, 0, 0, 0, 0, 1, 5'd1, 32'h10, 1, 5'd11, 32'hBB);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 5'd1, 5'd2, 5'd3, 0, 1, 5'd1, 32'h11, 0, 0, 0);
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL starve_early_stall[%0d] got=%0b exp=0", i, obs_stall); end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1, 5'd1, 5'd2, 5'd3, 0, 1, 5'd1, 32'h12, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL starve_freeze_stall[%0d] got=%0b exp=1", i, obs_stall); end
    end
    cycle(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL starve_gap_stall got=%0b exp=1", obs_stall); end
    checks++; if (obs_we !== 1'b1 || obs_waddr !== 5'd11 || obs_wdata !== 32'hBB) begin
      errors++; $display("FAIL starve_pop got=%0b/%0d/%h exp=1/11/bb", obs_we, obs_waddr, obs_wdata); end
    cycle(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL starve_unfreeze got=%0b exp=0", obs_stall); end
  endtask

  task automatic test_limits();
    for (int r = 1; r <= 4; r++) begin
      cycle(1, 0, 0, 5'(r), 1, 0, 0, 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL limit_issue[%0d] got=%0b exp=0", r, obs_stall); end
    end
    checks++; if (obs_busy !== 32'h1E) begin errors++; $display("FAIL limit_busy got=%h exp=1e", obs_busy); end
    cycle(1, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL limit_fifth_md got=%0b exp=1", obs_stall); end
    cycle(1, 5'd6, 5'd7, 5'd12, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL limit_non_md got=%0b exp=0", obs_stall); end
    cycle(0, 0, 0, 0, 0, 1, 5'd20, 32'h1, 1, 5'd1, 32'hC1);
    cycle(0, 0, 0, 0, 0, 1, 5'd21, 32'h2, 1, 5'd2, 32'hC2);
    cycle(0, 0, 0, 0, 0, 1, 5'd22, 32'h3, 0, 0, 0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL limit_full got=%0b exp=0", obs_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL midreset_busy got=%h exp=0", bus.busy_mask); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%0b exp=1", bus.md_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midreset_we got=%0b exp=0", bus.rf_we); end
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle();
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL midreset_empty_we got=%0b exp=0", obs_we); end
  endtask

  task automatic test_random();
    logic       iv, imd, wv, mv;
    logic [4:0] rs, rt, rd, wr, mr;
    for (int i = 0; i < 400; i++) begin
      iv  = 1'($urandom_range(0, 1));
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imd = ($urandom_range(0, 9) < 4);
      wv  = ($urandom_range(0, 9) < 4);
      wr  = 5'($urandom_range(0, 7));
      mv  = ($urandom_range(0, 9) < 3);
      mr  = 5'($urandom_range(0, 7));
      cycle(iv, rs, rt, rd, imd, wv, wr, $urandom, mv, mr, $urandom);
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", i, obs_stall, exp_stall); end
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", i, obs_ready, exp_ready); end
      checks++; if (obs_we !== exp_we) begin errors++; $display("FAIL rnd_we[%0d] got=%0b exp=%0b", i, obs_we, exp_we); end
      checks++; if (obs_busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d] got=%h exp=%h", i, obs_busy, m_busy); end
      if (exp_we) begin
        checks++; if (obs_waddr !== m_waddr || obs_wdata !== m_wdata) begin
          errors++; $display("FAIL rnd_write[%0d] got=%0d/%h exp=%0d/%h", i, obs_waddr, obs_wdata, m_waddr, m_wdata); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rs = '0; bus.issue_rt = '0; bus.issue_rd = '0; bus.issue_md = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.md_valid = 1'b0; bus.md_reg = '0; bus.md_data = '0;
    @(negedge clock);
    test_reset();
    test_wb_only();
    test_raw();
    test_conflict();
    test_starvation();
    test_limits();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
